// File: rtl/uart_kbd_pkg.sv
// Shared Hack memory-map constants and UART receiver state encoding.
// Imported by the keyboard receiver, its top level and the bench.
package uart_kbd_pkg;

  localparam logic [14:0] KBD_ADDR_DEFAULT = 15'h6000;
  localparam logic [14:0] LED_ADDR         = 15'h4000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // True when the CPU stores to the keyboard register, which acknowledges the key.
  function automatic logic is_kbd_write(input logic       wr,
                                        input logic [14:0] addr,
                                        input logic [14:0] kbd_addr);
    return wr && (addr == kbd_addr);
  endfunction

endpackage

// File: rtl/uart_kbd_if.sv
// CPU data-memory side of the keyboard register: address, write strobe
// and the register value the computer muxes onto inM.
interface uart_kbd_if;
  logic [14:0] addressM;
  logic        writeM;
  logic [15:0] kbdOut;

  modport master (output addressM, output writeM, input  kbdOut);
  modport slave  (input  addressM, input  writeM, output kbdOut);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM,
// one-cycle valid / frameErr pulses with the received byte.
module uart_rx
  import uart_kbd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frameErr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state_reg;
  logic             rx_meta_reg;
  logic             rx_sync_reg;
  logic             rx_prev_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       data_reg;
  logic             valid_reg;
  logic             frame_err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      rx_meta_reg   <= 1'b1;
      rx_sync_reg   <= 1'b1;
      rx_prev_reg   <= 1'b1;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rx_meta_reg   <= rx;
      rx_sync_reg   <= rx_meta_reg;
      rx_prev_reg   <= rx_sync_reg;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          cnt_reg     <= '0;
          bit_idx_reg <= '0;
          // Edge-qualified start: a line still low after reset or a framing
          // error is not mistaken for a new start bit.
          if (rx_prev_reg && !rx_sync_reg) begin
            state_reg <= START;
          end
        end

        START: begin
          if (cnt_reg == HALF_CNT) begin
            cnt_reg   <= '0;
            state_reg <= rx_sync_reg ? IDLE : DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (cnt_reg == FULL_CNT) begin
            cnt_reg     <= '0;
            shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 1'b1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        STOP: begin
          if (cnt_reg == FULL_CNT) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
            if (rx_sync_reg) begin
              valid_reg <= 1'b1;
              data_reg  <= shift_reg;
            end else begin
              frame_err_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign data     = data_reg;
  assign valid    = valid_reg;
  assign frameErr = frame_err_reg;

endmodule

// File: rtl/uart_kbd.sv
// Hack keyboard register fed by a UART: latches each received byte,
// cleared when the CPU writes to the keyboard address.
module uart_kbd
  import uart_kbd_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [14:0] KBD_ADDR     = KBD_ADDR_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  uart_kbd_if.slave  cpu,
  output logic       rxError
);

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_frame_err;
  logic [15:0] kbd_reg;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .data     (rx_data),
    .valid    (rx_valid),
    .frameErr (rx_frame_err)
  );

  // A load beats a same-cycle clear so a keystroke is never dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_reg <= '0;
    end else if (rx_valid) begin
      kbd_reg <= {8'h00, rx_data};
    end else if (is_kbd_write(cpu.writeM, cpu.addressM, KBD_ADDR)) begin
      kbd_reg <= '0;
    end
  end

  assign cpu.kbdOut = kbd_reg;
  assign rxError    = rx_frame_err;

endmodule

// File: tb/tb_uart_kbd.sv
// Scoreboard bench for uart_kbd at 4 clocks per bit: stimulus pushes
// expected register events, a negedge monitor pops and checks them.
module tb_uart_kbd;
  import uart_kbd_pkg::*;

  localparam int CPB = 4;
  // Edges from the first start-bit edge to the stop sample and to the load.
  localparam int unsigned ERR_LAT  = 41;
  localparam int unsigned LOAD_LAT = 42;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;
  logic rxError;

  uart_kbd_if bus ();

  uart_kbd #(
    .CLKS_PER_BIT (CPB),
    .KBD_ADDR     (15'h6000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .cpu     (bus),
    .rxError (rxError)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] kbd;
    logic        err;
    int unsigned at;
    string       tag;
  } ev_t;

  ev_t         exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] last_kbd    = 16'h0000;
  logic [15:0] model_kbd   = 16'h0000;
  logic [15:0] mem_out     = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic push_ev(input logic [15:0] kbd, input logic err, input int unsigned at,
                         input string tag);
    ev_t e;
    e.kbd = kbd;
    e.err = err;
    e.at  = at;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Any change of kbdOut or an rxError pulse is a DUT response.
  always @(negedge clk) begin
    ev_t e;
    if (bus.kbdOut !== last_kbd || rxError !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("spurious", {15'b0, rxError, bus.kbdOut}, {16'b0, last_kbd});
      end else begin
        e = exp_q.pop_front();
        check({e.tag, " kbdOut"},  {16'b0, bus.kbdOut}, {16'b0, e.kbd});
        check({e.tag, " rxError"}, {31'b0, rxError},    {31'b0, e.err});
        check({e.tag, " cycle"},   cyc,                 e.at);
      end
    end
    last_kbd = bus.kbdOut;
  end

  // mode 0: no response expected, 1: valid load, 2: framing error.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int mode,
                            input bit clr_at_load, input string tag);
    logic [9:0]  bits;
    int unsigned t0;
    bits = {stop, b, 1'b0};
    @(posedge clk); #1;
    t0 = cyc;
    if (mode == 1) begin
      model_kbd = {8'h00, b};
      push_ev(model_kbd, 1'b0, t0 + LOAD_LAT, tag);
    end else if (mode == 2) begin
      push_ev(model_kbd, 1'b1, t0 + ERR_LAT, tag);
    end
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    if (clr_at_load) begin
      @(posedge clk); #1;
      bus.addressM = 15'h6000;
      bus.writeM   = 1'b1;
      @(posedge clk); #1;
      bus.writeM   = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic cpu_cycle(input logic [14:0] a, input logic w);
    bus.addressM = a;
    bus.writeM   = w;
    @(posedge clk); #1;
    bus.writeM   = 1'b0;
  endtask

  initial begin
    logic [15:0] key;
    bus.addressM = 15'h0000;
    bus.writeM   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset kbdOut",  {16'b0, bus.kbdOut}, 32'h0);
    check("reset rxError", {31'b0, rxError},    32'h0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    send_frame(8'h41, 1'b1, 1, 1'b0, "byte41");

    cpu_cycle(15'h4000, 1'b1);
    cpu_cycle(15'h6000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("other-addr write/read kbdOut", {16'b0, bus.kbdOut}, 32'h0041);

    model_kbd = 16'h0000;
    push_ev(16'h0000, 1'b0, cyc + 1, "kbd_clear");
    cpu_cycle(15'h6000, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    send_frame(8'h5A, 1'b0, 2, 1'b0, "frame_err");
    send_frame(8'h7E, 1'b1, 1, 1'b0, "byte7E");
    send_frame(8'h33, 1'b1, 1, 1'b1, "load_vs_clear");

    // One-cycle low glitch must not start a frame.
    @(posedge clk); #1;
    rx = 1'b0;
    @(posedge clk); #1;
    rx = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    check("glitch kbdOut", {16'b0, bus.kbdOut}, 32'h0033);

    send_frame(8'h22, 1'b1, 1, 1'b0, "byte22");

    fork
      send_frame(8'hFF, 1'b1, 0, 1'b0, "aborted");
      begin
        repeat (20) @(posedge clk);
        #2;
        model_kbd = 16'h0000;
        push_ev(16'h0000, 1'b0, cyc, "mid_frame_reset");
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    check("post-reset kbdOut", {16'b0, bus.kbdOut}, 32'h0000);

    send_frame(8'h0D, 1'b1, 1, 1'b0, "byte0D");
    send_frame(8'h0F, 1'b1, 1, 1'b0, "byte0F");

    // Polling loop of the Hack program: read KBD, store it to the LED word.
    for (int i = 0; i < 3; i++) begin
      bus.addressM = 15'h6000;
      bus.writeM   = 1'b0;
      @(posedge clk); #1;
      key = bus.kbdOut;
      bus.addressM = LED_ADDR;
      bus.writeM   = 1'b1;
      @(posedge clk);
      mem_out = key;
      #1;
      bus.writeM   = 1'b0;
    end
    check("system memOut", {16'b0, mem_out}, 32'h000F);
    check("system kbdOut kept", {16'b0, bus.kbdOut}, 32'h000F);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_kbd.md
UART_KBD -- requirements
Module: uart_kbd

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per UART bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 The block SHALL have parameter KBD_ADDR, default 15'h6000, giving the Hack keyboard register address.
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock and the only clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous UART serial line, idle high, 8N1 format, LSB first.
REQ-006 The block SHALL have port addressM, input, 15 bits: the CPU data-memory address.
REQ-007 The block SHALL have port writeM, input, 1 bit: the CPU data-memory write strobe.
REQ-008 The block SHALL have port kbdOut, output, 16 bits: the keyboard register value muxed by the computer onto CPU inM when addressM equals KBD_ADDR.
REQ-009 The block SHALL have port rxError, output, 1 bit: a one-cycle pulse on a framing error.

Function
REQ-010 rx SHALL pass through a two-flop synchronizer, reset to 1, before any use.
REQ-011 The receive FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE -> START on a synchronized falling edge of rx; the baud counter clears.
REQ-012 In START, at count CLKS_PER_BIT/2 - 1 (integer division), the FSM SHALL sample rx.
- rx low: go to DATA, counter cleared.
- rx high (glitch): go to IDLE with no other effect.
REQ-013 In DATA, the FSM SHALL sample rx every CLKS_PER_BIT cycles (mid-bit) into a shift register, LSB first.
- A 3-bit index tracks the bit; after bit 7 the FSM goes to STOP.
REQ-014 In STOP, after CLKS_PER_BIT cycles, the FSM SHALL sample rx and return to IDLE.
- rx high: the byte is valid.
- rx low: rxError pulses for exactly one cycle, the byte is discarded, and kbdOut is unchanged.
REQ-015 On a valid byte, kbdOut SHALL become {8'h00, byte} on the clock edge following the stop-bit sample, i.e. 1 cycle of latency.
REQ-016 kbdOut SHALL hold its value until it is cleared or overwritten.
- A later valid byte overwrites it; there is no queue, and the newest byte wins.
REQ-017 A cycle with writeM=1 and addressM=KBD_ADDR SHALL clear kbdOut to 16'h0000 on that clock edge; the CPU thus acknowledges a key by writing to the KBD address.
REQ-018 If a clear and a valid-byte load occur in the same cycle, the load SHALL win, so a keystroke is never lost.
REQ-019 Writes to any other address, and reads of any address, SHALL not affect kbdOut.
REQ-020 The FSM SHALL be independent of the CPU port; a clear SHALL not disturb a reception in progress.
REQ-021 The baud counter width SHALL be $clog2(CLKS_PER_BIT) bits; it SHALL wrap only via explicit clear and never overflow silently.

Reset
REQ-022 Asserting reset SHALL asynchronously force the following, regardless of FSM state (including mid-frame):
- FSM state to IDLE
- counter, bit index and shift register to 0
- synchronizer flops to 1
- kbdOut to 16'h0000
- rxError to 0
REQ-023 After reset deassertion, the block SHALL ignore rx until a fresh falling edge; a partially received frame SHALL never be completed.

Structure
REQ-024 The FSM state encoding and the KBD_ADDR default SHALL live in the shared Hack memory-map include alongside the LED address 0x4000.
REQ-025 The receiver SHALL be a sub-module uart_rx with outputs data[7:0], valid (1-cycle pulse) and frameErr; uart_kbd SHALL add only the register, clear logic and address decode.

Verification (CLKS_PER_BIT=4)
REQ-026 Send 8'h41 with a valid stop bit -> kbdOut=16'h0041 one cycle after the stop sample, rxError never pulses.
REQ-027 Hold kbdOut=0x0041, then apply writeM=1 with addressM=15'h6000 -> kbdOut=0x0000 on the next edge; the same write with addressM=15'h4000 -> kbdOut stays 0x0041.
REQ-028 Send 8'h5A with stop bit 0 -> rxError high for exactly 1 cycle, kbdOut keeps its prior value.
REQ-029 Time a KBD clear write to coincide with the valid-load edge of 8'h33 -> kbdOut=16'h0033.
REQ-030 Drive rx low for 1 cycle only (glitch) -> FSM returns to IDLE, kbdOut unchanged; then assert reset mid-DATA of 8'hFF -> kbdOut=0, no load after release, and a following 8'h0D is received correctly.
REQ-031 System level: run a Hack program that loops on reading KBD and copies it to the LED address 0x4000 (no write to KBD), send 8'h0F -> memOut=16'h000F.
